// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST segment-test stage.
// Optional feature macro used by this slice: FAST_ARC_LEN_EN.
package fast_pkg;

    localparam int RING_SIZE = 16;
    localparam int ARC_W     = 5;
    localparam int COORD_W   = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               polarity;
        logic [ARC_W-1:0]   arc;
    } corner_t;

endpackage

// File: rtl/fast_arc_detect.sv
// Combinational circular run finder for one 16-pixel circle mask.
// FAST_ARC_LEN_EN builds the full run-length scan; otherwise only ARC_LEN windows are matched.
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int ARC_LEN = 9
) (
    input  logic [RING_SIZE-1:0] mask,
    output logic                 qualify,
    output logic [ARC_W-1:0]     run
);

`ifdef FAST_ARC_LEN_EN
    logic [2*RING_SIZE-1:0] doubled;
    logic [5:0]             cur;
    logic [5:0]             best;

    // Scanning the doubled mask lets a run that crosses bit 15 -> bit 0 be counted whole.
    always_comb begin
        doubled = {mask, mask};
        cur     = '0;
        best    = '0;
        for (int i = 0; i < 2*RING_SIZE; i++) begin
            if (doubled[i]) begin
                cur = cur + 6'd1;
            end else begin
                cur = '0;
            end
            if (cur > best) begin
                best = cur;
            end
        end
        if (best > 6'(RING_SIZE)) begin
            best = 6'(RING_SIZE);
        end
        run     = best[ARC_W-1:0];
        qualify = (best >= 6'(ARC_LEN));
    end
`else
    logic [RING_SIZE-1:0] win;

    always_comb begin
        win = '1;
        for (int s = 0; s < RING_SIZE; s++) begin
            for (int j = 0; j < ARC_LEN; j++) begin
                win[s] = win[s] & mask[(s + j) % RING_SIZE];
            end
        end
    end

    assign qualify = |win;
    assign run     = ARC_W'(ARC_LEN);
`endif

endmodule

// File: rtl/fast_segment_test.sv
// FAST segment test: tags qualifying circle masks with (x,y) and polarity, buffers them in a small FIFO.
// FAST_ARC_LEN_EN selects whether corner_arc reports the measured run or the constant ARC_LEN.
module fast_segment_test
    import fast_pkg::*;
#(
    parameter int ARC_LEN    = 9,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          in_valid,
    input  logic [15:0]                   bright_mask,
    input  logic [15:0]                   dark_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  corner_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] corner_y,
    output logic                          corner_polarity,
    output logic [4:0]                    corner_arc,
    output logic                          overflow
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [XW-1:0] x_cnt, beat_x, x_next;
    logic [YW-1:0] y_cnt, beat_y, y_next;

    // frame_start pins the coincident beat to (0,0) so the next beat lands on (1,0).
    always_comb begin
        beat_x = frame_start ? '0 : x_cnt;
        beat_y = frame_start ? '0 : y_cnt;
        x_next = beat_x + XW'(1);
        y_next = beat_y;
        if (beat_x == XW'(IMG_WIDTH - 1)) begin
            x_next = '0;
            y_next = (beat_y == YW'(IMG_HEIGHT - 1)) ? '0 : beat_y + YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_valid) begin
            x_cnt <= x_next;
            y_cnt <= y_next;
        end else if (frame_start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end
    end

    logic          s1_valid;
    logic [15:0]   s1_bright, s1_dark;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_bright <= '0;
            s1_dark   <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_bright <= bright_mask;
            s1_dark   <= dark_mask;
            s1_x      <= beat_x;
            s1_y      <= beat_y;
        end
    end

    logic             bright_q, dark_q;
    logic [ARC_W-1:0] bright_run, dark_run;

    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_bright (
        .mask    (s1_bright),
        .qualify (bright_q),
        .run     (bright_run)
    );

    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_dark (
        .mask    (s1_dark),
        .qualify (dark_q),
        .run     (dark_run)
    );

    corner_t entry;
    logic    push;

    always_comb begin
        entry.x        = COORD_W'(s1_x);
        entry.y        = COORD_W'(s1_y);
        entry.polarity = bright_q;
        entry.arc      = bright_q ? bright_run : dark_run;
        push           = s1_valid && (bright_q || dark_q);
    end

    corner_t       mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, pop, do_push, drop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = !empty && out_ready;
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= entry;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (frame_start) begin
                overflow <= 1'b0;
            end
        end
    end

    corner_t head;
    logic    unused_head_bits;

    assign head             = mem[rd_ptr[AW-1:0]];
    assign out_valid        = !empty;
    assign corner_x         = head.x[XW-1:0];
    assign corner_y         = head.y[YW-1:0];
    assign corner_polarity  = head.polarity;
    assign corner_arc       = head.arc;
    assign unused_head_bits = ^{head.x[COORD_W-1:XW], head.y[COORD_W-1:YW]};

endmodule

// File: tb/tb_fast_segment_test.sv
// Self-checking bench for fast_segment_test: directed cases plus randomized traffic against a queue model.
// Expected corner_arc follows FAST_ARC_LEN_EN (measured run when defined, ARC_LEN otherwise).
module tb_fast_segment_test;

    localparam int ARC_LEN    = 9;
    localparam int IMG_WIDTH  = 4;
    localparam int IMG_HEIGHT = 3;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        in_valid;
    logic [15:0] bright_mask;
    logic [15:0] dark_mask;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  corner_x;
    logic [1:0]  corner_y;
    logic        corner_polarity;
    logic [4:0]  corner_arc;
    logic        overflow;

    fast_segment_test #(
        .ARC_LEN    (ARC_LEN),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .in_valid        (in_valid),
        .bright_mask     (bright_mask),
        .dark_mask       (dark_mask),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .corner_x        (corner_x),
        .corner_y        (corner_y),
        .corner_polarity (corner_polarity),
        .corner_arc      (corner_arc),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int pol;
        int arc;
    } corner_m;

    int      tests = 0;
    int      fails = 0;
    bit      check_en = 1'b0;
    corner_m model_q[$];
    corner_m got[$];
    corner_m pend;
    bit      pend_valid;
    bit      model_ovf;
    int      mx, my;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Longest circular run found by walking forward from every start bit.
    function automatic int longest_run(input logic [15:0] m);
        int best;
        int len;
        best = 0;
        for (int s = 0; s < 16; s++) begin
            len = 0;
            while (len < 16 && m[(s + len) % 16]) len++;
            if (len > best) best = len;
        end
        return best;
    endfunction

    function automatic int exp_arc(input int run);
`ifdef FAST_ARC_LEN_EN
        return run;
`else
        return ARC_LEN;
`endif
    endfunction

    // Reference model: a corner seen at one edge joins the queue at the following edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            pend_valid = 1'b0;
            model_ovf  = 1'b0;
            mx         = 0;
            my         = 0;
        end else begin
            bit drop;
            int bx, by, br, dr;
            drop = 1'b0;
            if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
            if (pend_valid) begin
                if (model_q.size() < FIFO_DEPTH) model_q.push_back(pend);
                else drop = 1'b1;
            end
            if (drop) model_ovf = 1'b1;
            else if (frame_start) model_ovf = 1'b0;
            pend_valid = 1'b0;
            if (in_valid) begin
                bx = frame_start ? 0 : mx;
                by = frame_start ? 0 : my;
                br = longest_run(bright_mask);
                dr = longest_run(dark_mask);
                if (br >= ARC_LEN) begin
                    pend       = '{bx, by, 1, exp_arc(br)};
                    pend_valid = 1'b1;
                end else if (dr >= ARC_LEN) begin
                    pend       = '{bx, by, 0, exp_arc(dr)};
                    pend_valid = 1'b1;
                end
                mx = (bx + 1) % IMG_WIDTH;
                my = (bx + 1 == IMG_WIDTH) ? (by + 1) % IMG_HEIGHT : by;
            end else if (frame_start) begin
                mx = 0;
                my = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_out_valid", int'(out_valid), int'(model_q.size() != 0));
            checkOutput("model_overflow", int'(overflow), int'(model_ovf));
            if (model_q.size() != 0 && out_valid) begin
                checkOutput("model_corner_x", int'(corner_x), model_q[0].x);
                checkOutput("model_corner_y", int'(corner_y), model_q[0].y);
                checkOutput("model_polarity", int'(corner_polarity), model_q[0].pol);
                checkOutput("model_arc", int'(corner_arc), model_q[0].arc);
            end
        end
        if (rst_n === 1'b1 && out_valid && out_ready)
            got.push_back('{int'(corner_x), int'(corner_y), int'(corner_polarity), int'(corner_arc)});
    end

    task automatic applyStimulus(input logic fs, input logic iv, input logic [15:0] b, input logic [15:0] d);
        frame_start = fs;
        in_valid    = iv;
        bright_mask = b;
        dark_mask   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic logic [15:0] gen_mask();
        logic [31:0] m;
        int          len, r;
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1, 2: begin
                len = $urandom_range(6, 16);
                r   = $urandom_range(0, 15);
                m   = (32'd1 << len) - 32'd1;
                m   = (m << r) | (m >> (16 - r));
                return m[15:0];
            end
            default: return 16'h0;
        endcase
    endfunction

    initial begin
        int xs[6];
        int ys[6];
        rst_n       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        bright_mask = '0;
        dark_mask   = '0;
        out_ready   = 1'b0;

        checkOutput("pin_run_01FF", longest_run(16'h01FF), 9);
        checkOutput("pin_run_F81F", longest_run(16'hF81F), 10);
        checkOutput("pin_run_00FF", longest_run(16'h00FF), 8);
        checkOutput("pin_run_FFFF", longest_run(16'hFFFF), 16);
        checkOutput("pin_run_0000", longest_run(16'h0000), 0);

        #3;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_corner_x", int'(corner_x), 0);
        checkOutput("reset_corner_y", int'(corner_y), 0);
        checkOutput("reset_polarity", int'(corner_polarity), 0);
        checkOutput("reset_arc", int'(corner_arc), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(2);

        // Directed: latency, wrap run, non-qualifying mask, dark polarity, overflow.
        applyStimulus(1'b1, 1'b1, 16'h01FF, 16'h0000);
        checkOutput("latency_not_yet", int'(out_valid), 0);
        applyStimulus(1'b0, 1'b1, 16'hF81F, 16'h0000);
        checkOutput("latency_2_valid", int'(out_valid), 1);
        checkOutput("first_polarity", int'(corner_polarity), 1);
        checkOutput("first_arc", int'(corner_arc), exp_arc(9));
        applyStimulus(1'b0, 1'b1, 16'h00FF, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h01FF);
        idle(2);
        checkOutput("overflow_set", int'(overflow), 1);
        checkOutput("held_head_x", int'(corner_x), 0);
        got.delete();
        out_ready = 1'b1;
        idle(8);
        checkOutput("drain_count", got.size(), 4);
        if (got.size() == 4) begin
            checkOutput("drain0_x", got[0].x, 0);
            checkOutput("drain0_arc", got[0].arc, exp_arc(9));
            checkOutput("drain1_x", got[1].x, 1);
            checkOutput("drain1_arc", got[1].arc, exp_arc(10));
            checkOutput("drain2_x", got[2].x, 3);
            checkOutput("drain2_pol", got[2].pol, 0);
            checkOutput("drain2_arc", got[2].arc, exp_arc(16));
            checkOutput("drain3_x", got[3].x, 0);
            checkOutput("drain3_y", got[3].y, 1);
        end
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
        checkOutput("overflow_cleared", int'(overflow), 0);

        // Coordinate walk across a line wrap.
        got.delete();
        applyStimulus(1'b1, 1'b1, 16'h01FF, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h01FF, 16'h0);
        idle(4);
        xs = '{0, 1, 2, 3, 0, 1};
        ys = '{0, 0, 0, 0, 1, 1};
        checkOutput("coord_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checkOutput("coord_x", got[i].x, xs[i]);
            checkOutput("coord_y", got[i].y, ys[i]);
        end

        // Asynchronous reset with buffered corners.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0);
        idle(2);
        checkOutput("buffered_before_reset", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", int'(out_valid), 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        checkOutput("no_stale_after_reset", int'(out_valid), 0);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0), gen_mask(), gen_mask());
        end
        out_ready = 1'b1;
        idle(10);
        checkOutput("final_drained", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
